// File: rtl/hit_event_sequencer.sv
// hit_event_sequencer
//   Collects per-pixel collision codes over a video frame and, at each frame
//   boundary, turns them into game events: lives, score, freeze and
//   invulnerability timing.
//
// Ports
//   clk             : clock, all state on the rising edge
//   reset           : asynchronous, active-high reset
//   startOfFrame    : one-cycle frame boundary pulse
//   hit_type[2:0]   : per-pixel code (0 none, 1 life, 2 coin, 3 good, 4 bad)
//   start_game      : level-sampled start request (honoured in IDLE / GAME_OVER)
//   game_state[1:0] : 0 IDLE, 1 PLAY, 2 FREEZE, 3 GAME_OVER (FSM state, directly)
//   lives[2:0]      : current life count
//   score[15:0]     : current score, saturating at 0xFFFF
//   freeze          : high whenever game_state != PLAY
//   invulnerable    : high while the invulnerability counter is nonzero
//   life_lost_pulse : one cycle after a boundary that deducted a life
//   score_pulse     : one cycle after a boundary that changed the score
//
// Handshake: there is no flow control. Each event pulse is a single-cycle
// strobe that is valid together with the updated lives/score in the same cycle.
module hit_event_sequencer #(
  parameter int START_LIVES   = 3,
  parameter int MAX_LIVES     = 5,
  parameter int FREEZE_FRAMES = 60,
  parameter int INVULN_FRAMES = 120,
  parameter int COIN_POINTS   = 10,
  parameter int RING_POINTS   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [2:0]  hit_type,
  input  logic        start_game,
  output logic [1:0]  game_state,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic        freeze,
  output logic        invulnerable,
  output logic        life_lost_pulse,
  output logic        score_pulse
);

  localparam int FW = $clog2(FREEZE_FRAMES + 2);
  localparam int IW = $clog2(INVULN_FRAMES + 2);
  localparam logic [2:0] MAX_L = 3'(MAX_LIVES);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PLAY      = 2'd1,
    S_FREEZE    = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [2:0]    lives_n;
  logic [15:0]   score_n;
  logic [FW-1:0] frz_cnt, frz_n;
  logic [IW-1:0] inv_cnt, inv_n;
  // flags: {bad, life, coin, good}; prev: {life, coin, good} of the last frame
  logic [3:0]    flags, flags_n, hit_vec;
  logic [2:0]    prev, prev_n, edges;
  logic          lost_n, spulse_n;
  logic [17:0]   sum;

  assign hit_vec = {hit_type == 3'd4, hit_type == 3'd1,
                    hit_type == 3'd2, hit_type == 3'd3};
  assign edges   = flags[2:0] & ~prev;
  assign sum     = 18'(score) + (edges[1] ? 18'(COIN_POINTS) : 18'd0)
                              + (edges[0] ? 18'(RING_POINTS) : 18'd0);

  always_comb begin
    state_n  = state;
    lives_n  = lives;
    score_n  = score;
    frz_n    = frz_cnt;
    inv_n    = inv_cnt;
    lost_n   = 1'b0;
    spulse_n = 1'b0;
    flags_n  = flags | hit_vec;
    prev_n   = prev;
    if (startOfFrame) begin
      // The boundary cycle's own hit already belongs to the new frame.
      flags_n = hit_vec;
      prev_n  = flags[2:0];
    end
    case (state)
      S_IDLE, S_GAME_OVER: begin
        if (start_game) begin
          state_n = S_PLAY;
          lives_n = 3'(START_LIVES);
          score_n = 16'd0;
          frz_n   = '0;
          inv_n   = '0;
          prev_n  = '0;
        end
      end
      S_PLAY: begin
        if (startOfFrame) begin
          if (inv_cnt != '0) inv_n = inv_cnt - 1'b1;
          // bad is judged against the counter value before this decrement
          if (flags[3] && inv_cnt == '0) begin
            lost_n = 1'b1;
            if (lives <= 3'd1) begin
              state_n = S_GAME_OVER;
              lives_n = 3'd0;
            end else begin
              state_n = S_FREEZE;
              lives_n = lives - 3'd1;
              frz_n   = FW'(FREEZE_FRAMES);
            end
          end else begin
            if (edges[2] && lives < MAX_L) lives_n = lives + 3'd1;
            score_n  = (sum > 18'h0FFFF) ? 16'hFFFF : sum[15:0];
            spulse_n = (score_n != score);
          end
        end
      end
      S_FREEZE: begin
        if (startOfFrame) begin
          if (frz_cnt <= FW'(1)) begin
            state_n = S_PLAY;
            frz_n   = '0;
            inv_n   = IW'(INVULN_FRAMES);
          end else begin
            frz_n = frz_cnt - 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      lives           <= 3'd0;
      score           <= 16'd0;
      frz_cnt         <= '0;
      inv_cnt         <= '0;
      flags           <= '0;
      prev            <= '0;
      freeze          <= 1'b1;
      invulnerable    <= 1'b0;
      life_lost_pulse <= 1'b0;
      score_pulse     <= 1'b0;
    end else begin
      state           <= state_n;
      lives           <= lives_n;
      score           <= score_n;
      frz_cnt         <= frz_n;
      inv_cnt         <= inv_n;
      flags           <= flags_n;
      prev            <= prev_n;
      freeze          <= (state_n != S_PLAY);
      invulnerable    <= (inv_n != '0);
      life_lost_pulse <= lost_n;
      score_pulse     <= spulse_n;
    end
  end

  assign game_state = state;

endmodule

// File: doc/hit_event_sequencer.md
HIT_EVENT_SEQUENCER -- requirements
Module: hit_event_sequencer

Interface
REQ-001 Parameter START_LIVES, default 3, lives loaded on game start.
REQ-002 Parameter MAX_LIVES, default 5, lives saturation ceiling.
REQ-003 Parameter FREEZE_FRAMES, default 60, frames the player is frozen after losing a life.
REQ-004 Parameter INVULN_FRAMES, default 120, frames of invulnerability after a freeze ends.
REQ-005 Parameter COIN_POINTS, default 10, score added per coin pickup.
REQ-006 Parameter RING_POINTS, default 5, score added per ring/rail good collision.
REQ-007 The block SHALL have one clock, clk, input, 1 bit; all state is on its rising edge.
REQ-008 The block SHALL have reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 startOfFrame, input, 1 bit: one-cycle pulse marking the frame boundary.
REQ-010 hit_type, input, 3 bits, per-pixel collision code: 0 none, 1 life, 2 coin, 3 good, 4 bad; 5-7 are ignored.
REQ-011 start_game, input, 1 bit: level-sampled game start request.
REQ-012 game_state, output, 2 bits: 0 IDLE, 1 PLAY, 2 FREEZE, 3 GAME_OVER.
REQ-013 lives, output, 3 bits: current life count.
REQ-014 score, output, 16 bits: current score.
REQ-015 freeze, output, 1 bit: high whenever game_state != PLAY; this halts player motion.
REQ-016 invulnerable, output, 1 bit: high while the invulnerability counter is nonzero.
REQ-017 life_lost_pulse, output, 1 bit: one-cycle pulse when a life is deducted.
REQ-018 score_pulse, output, 1 bit: one-cycle pulse when the score changes.

Function
REQ-019 The block SHALL hold four sticky per-frame flags (bad, life, coin, good), each set by any cycle with the matching hit_type.
REQ-020 All evaluation SHALL occur only in the cycle startOfFrame=1, using the flags accumulated since the previous pulse.
REQ-021 In that same cycle the flags SHALL be cleared; a hit present in that cycle SHALL count toward the new frame.
REQ-022 The block SHALL keep the life, coin and good flags of the previous frame; each effect applies only on a rising edge (flag set now, clear in the previous frame).
REQ-023 In IDLE or GAME_OVER with start_game=1: go to PLAY, lives=START_LIVES, score=0, both counters=0, previous-frame flags cleared.
REQ-024 In PLAY, if bad is set and invulnerable=0 at the boundary:
- lives decrements by 1 and life_lost_pulse fires.
- If lives was 1: go to GAME_OVER with lives=0.
- Otherwise: go to FREEZE with freeze counter=FREEZE_FRAMES.
- Life, coin and good effects of that frame are discarded.
REQ-025 In PLAY, if bad is set while invulnerable=1, bad SHALL be ignored and the other effects apply normally.
REQ-026 Life rising edge: lives+1, saturating at MAX_LIVES.
REQ-027 Coin rising edge: score+COIN_POINTS.
REQ-028 Good rising edge: score+RING_POINTS.
REQ-029 Coin and good in the same frame SHALL both add; score saturates at 0xFFFF.
REQ-030 score_pulse SHALL fire only if score actually changed, so there is no pulse at saturation.
REQ-031 In FREEZE, all hits SHALL be ignored and the counter decrements at each boundary.
REQ-032 In FREEZE, at the boundary where the counter reads 1: go to PLAY and load the invulnerability counter with INVULN_FRAMES.
REQ-033 The invulnerability counter SHALL decrement at each boundary in PLAY, stopping at 0.
REQ-034 A bad hit is evaluated against invulnerable as it was before that boundary's decrement.
REQ-035 start_game SHALL be ignored in PLAY and FREEZE.
REQ-036 Outputs SHALL be registered; an effect is visible the cycle after the startOfFrame pulse.
REQ-037 With no startOfFrame pulse, state, lives, score and the counters SHALL hold.

Reset
REQ-038 reset=1 SHALL immediately force: game_state=IDLE, lives=0, score=0, freeze=1, invulnerable=0, both pulses=0, all counters and flags=0.
REQ-039 Reset asserted mid-frame or mid-FREEZE SHALL discard pending flags; the first boundary after release evaluates nothing.

Verification
REQ-040 Reset, then start_game for 1 cycle -> game_state=1, lives=3, score=0, freeze=0.
REQ-041 PLAY, hit_type=2 for 5 pixels in each of frames N and N+1 -> score=10 after the N boundary, unchanged after N+1, score_pulse fires once.
REQ-042 PLAY with lives=3, hit_type=4 in a frame -> lives=2, life_lost_pulse, game_state=2 for 60 boundaries, then PLAY with invulnerable=1 for 120 boundaries; hit_type=4 during invulnerability leaves lives=2.
REQ-043 lives=1, hit_type=4 plus hit_type=1 in the same frame -> lives=0, game_state=3; then start_game -> lives=3, score=0.
REQ-044 Score preset near 0xFFFF (0xFFFA), coin and good in the same frame -> score=0xFFFF; repeated edges cause no further score_pulse.
REQ-045 Assert reset during FREEZE, with hit_type=1 pending -> IDLE, lives=0, no effect at the next startOfFrame.
